// File: rtl/crypto_alu_seq.sv
// rtl/crypto_alu_seq.sv - Multi-cycle crypto coprocessor: rotates, xorshift RNG, carry-less multiply.
// Optional build macro CRYPTO_ALU_CLMUL_R4_EN: CLMUL processes two multiplier bits per cycle.
module crypto_alu_seq #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RNG_SEED = 32'hDEADBEEF,
    parameter int          SH1      = 13,
    parameter int          SH2      = 17,
    parameter int          SH3      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [63:0] SEED_EXT = {32'd0, RNG_SEED};
    localparam logic [WIDTH-1:0] SEED_W = SEED_EXT[WIDTH-1:0];

`ifdef CRYPTO_ALU_CLMUL_R4_EN
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 2);
`else
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rng_q, rng_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               hi_q, hi_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   rn1, rn2, rn3;
    logic [2*WIDTH-1:0] rot_l, rot_r;
    logic [CNT_W-1:0]   rot_amt;
    logic [WIDTH-1:0]   simple_res;
    logic               simple_err;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   clmul_res;

    always_comb begin
        rn1 = rng_q ^ (rng_q << SH1);
        rn2 = rn1 ^ (rn1 >> SH2);
        rn3 = rn2 ^ (rn2 << SH3);
    end

    // Rotating the doubled operand avoids a special case for a zero amount.
    always_comb begin
        rot_amt = b[CNT_W-1:0];
        rot_l   = {a, a} << rot_amt;
        rot_r   = {a, a} >> rot_amt;
    end

    always_comb begin
        simple_res = '0;
        simple_err = 1'b0;
        case (op)
            3'b000:  simple_res = rot_l[2*WIDTH-1:WIDTH];
            3'b001:  simple_res = rot_r[WIDTH-1:0];
            3'b010:  simple_res = rn3;
            3'b011:  simple_res = (a == '0) ? SEED_W : a;
            default: simple_err = 1'b1;
        endcase
    end

`ifdef CRYPTO_ALU_CLMUL_R4_EN
    logic [CNT_W-1:0]   cnt_p1;
    logic [2*WIDTH-1:0] pp0, pp1;
    always_comb begin
        cnt_p1   = cnt_q + CNT_W'(1);
        pp0      = b_q[cnt_q]  ? ({{WIDTH{1'b0}}, a_q} << cnt_q)  : '0;
        pp1      = b_q[cnt_p1] ? ({{WIDTH{1'b0}}, a_q} << cnt_p1) : '0;
        acc_step = acc_q ^ pp0 ^ pp1;
    end
`else
    logic [2*WIDTH-1:0] pp0;
    always_comb begin
        pp0      = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
        acc_step = acc_q ^ pp0;
    end
`endif

    assign clmul_res = hi_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        rng_d    = rng_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op[2:1] == 2'b10) begin
                        a_d     = a;
                        b_d     = b;
                        hi_d    = op[0];
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        result_d = simple_res;
                        zero_d   = (simple_res == '0);
                        err_d    = simple_err;
                        if (op[2:1] == 2'b01) begin
                            rng_d = simple_res;
                        end
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == CNT_LAST) begin
                    result_d = clmul_res;
                    zero_d   = (clmul_res == '0);
                    err_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rng_q    <= SEED_W;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rng_q    <= rng_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_crypto_alu_seq.sv
// tb/tb_crypto_alu_seq.sv - Directed table-driven bench for crypto_alu_seq (WIDTH=32).
module tb_crypto_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        err;
    logic        busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

`ifdef CRYPTO_ALU_CLMUL_R4_EN
    localparam int CL_LAT = 1 + 16;
`else
    localparam int CL_LAT = 1 + 32;
`endif

    crypto_alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // lat counts edges from the issue edge (accept) up to the first edge where out_valid is seen.
    task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          input int hold, output logic [31:0] r, output logic z, output logic e,
                          output int lat, output logic rdy_ok, output logic stable_ok);
        in_valid = 1'b1;
        op = o;
        a = aa;
        b = bb;
        rdy_ok = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        z = zero;
        e = err;
        stable_ok = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (!out_valid || result !== r || zero !== z || err !== e) stable_ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic        z, e, rdy_ok, stable_ok;
        int          lat, exp_lat;

        vecs[0]  = '{3'b010, 32'h0,        32'h0,        32'h477D20B7, 1'b0, 1'b0};
        vecs[1]  = '{3'b000, 32'h80000001, 32'h4,        32'h00000018, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 32'h00000001, 32'h1,        32'h80000000, 1'b0, 1'b0};
        vecs[3]  = '{3'b000, 32'h12345678, 32'd32,       32'h12345678, 1'b0, 1'b0};
        vecs[4]  = '{3'b001, 32'h0000000F, 32'hFFFFFF23, 32'hE0000001, 1'b0, 1'b0};
        vecs[5]  = '{3'b011, 32'h0,        32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[6]  = '{3'b010, 32'h0,        32'h0,        32'h477D20B7, 1'b0, 1'b0};
        vecs[7]  = '{3'b011, 32'h1,        32'h0,        32'h00000001, 1'b0, 1'b0};
        vecs[8]  = '{3'b010, 32'h0,        32'h0,        32'h00042021, 1'b0, 1'b0};
        vecs[9]  = '{3'b100, 32'h3,        32'h3,        32'h00000005, 1'b0, 1'b0};
        vecs[10] = '{3'b101, 32'h80000000, 32'h2,        32'h00000001, 1'b0, 1'b0};
        vecs[11] = '{3'b100, 32'h80000000, 32'h2,        32'h00000000, 1'b1, 1'b0};
        vecs[12] = '{3'b110, 32'h12345678, 32'h1,        32'h00000000, 1'b1, 1'b1};
        vecs[13] = '{3'b000, 32'h00000001, 32'h1,        32'h00000002, 1'b0, 1'b0};
        vecs[14] = '{3'b111, 32'h1,        32'h1,        32'h00000000, 1'b1, 1'b1};
        vecs[15] = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 3'b000;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset busy",      {31'd0, busy},      32'd0);
        chk("reset result",    result,             32'd0);
        chk("reset zero",      {31'd0, zero},      32'd0);
        chk("reset err",       {31'd0, err},       32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            exp_lat = (vecs[i].op[2:1] == 2'b10) ? CL_LAT : 1;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i == 0) ? 3 : 0, r, z, e, lat, rdy_ok, stable_ok);
            chk($sformatf("vec%0d result", i), r, vecs[i].exp_res);
            chk($sformatf("vec%0d zero", i), {31'd0, z}, {31'd0, vecs[i].exp_zero});
            chk($sformatf("vec%0d err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d latency", i), lat, exp_lat);
            chk($sformatf("vec%0d in_ready low while busy", i), {31'd0, rdy_ok}, 32'd1);
            chk($sformatf("vec%0d out_valid held", i), {31'd0, stable_ok}, 32'd1);
            chk($sformatf("vec%0d released", i), {30'd0, out_valid, in_ready}, 32'd1);
        end

        // in_valid held high through CALC/DONE must not be queued or touch the RNG.
        run_op(3'b011, 32'h1, 32'h0, 0, r, z, e, lat, rdy_ok, stable_ok);
        chk("seed1 result", r, 32'h1);
        in_valid = 1'b1;
        op = 3'b100;
        a = 32'h3;
        b = 32'h3;
        @(posedge clk);
        #1;
        op = 3'b010;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("ignored-in_valid clmul latency", lat, CL_LAT);
        chk("ignored-in_valid clmul result", result, 32'h5);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        run_op(3'b010, 32'h0, 32'h0, 0, r, z, e, lat, rdy_ok, stable_ok);
        chk("rng not advanced by ignored request", r, 32'h00042021);

        // Asynchronous reset in CALC abandons the op and reseeds the RNG.
        in_valid = 1'b1;
        op = 3'b100;
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("async reset in_ready",  {31'd0, in_ready},  32'd1);
        chk("async reset busy",      {31'd0, busy},      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        chk("no output after abandoned op", {31'd0, out_valid}, 32'd0);
        run_op(3'b010, 32'h0, 32'h0, 0, r, z, e, lat, rdy_ok, stable_ok);
        chk("rng reseeded by reset", r, 32'h477D20B7);
        run_op(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, r, z, e, lat, rdy_ok, stable_ok);
        chk("post-reset clmul result", r, 32'h55555555);
        chk("post-reset clmul latency", lat, CL_LAT);
        chk("post-reset clmul held 5 cycles", {31'd0, stable_ok}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
